// File: rtl/pixel_scheduler.sv
// pixel_scheduler
// Frame sequencer feeding generate_ray. A start pulse launches a raster sweep
// (x fastest) over a PIXEL_W x PIXEL_H frame, one coordinate per accepted
// (stall=0) cycle. After the last pixel the ray pipeline is flushed for
// PIPE_LAT accepted cycles, then frame_done pulses and frame_count advances.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a frame (only honoured in IDLE)
//   abort        cancel the current frame, return to IDLE
//   stall        downstream stall; freezes all progress in SCAN/DRAIN
//   pixel_x/y    current coordinate (0 when not valid)
//   pixel_valid  coordinate carries a real pixel
//   busy         high in SCAN and DRAIN
//   frame_done   one-cycle pulse after the last drain step
//   frame_count  completed frames, wraps at 16 bits
//
// state | meaning
// IDLE  | waiting for start, outputs parked at 0
// SCAN  | presenting pixel coordinates in raster order
// DRAIN | flushing the downstream pipeline after the last pixel
module pixel_scheduler #(
  parameter int PIXEL_W  = 800,
  parameter int PIXEL_H  = 600,
  parameter int COORD_W  = 10,
  parameter int PIPE_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pixel_valid,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(PIXEL_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(PIXEL_H - 1);
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   drain_cnt, drain_cnt_nx;
  logic [COORD_W-1:0] x_nx, y_nx;
  logic               valid_nx, done_nx;
  logic [15:0]        count_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      drain_cnt   <= drain_cnt_nx;
      pixel_x     <= x_nx;
      pixel_y     <= y_nx;
      pixel_valid <= valid_nx;
      // busy is registered from the next state so it stays a pure flop output
      busy        <= (state_nx != IDLE);
      frame_done  <= done_nx;
      frame_count <= count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    x_nx         = pixel_x;
    y_nx         = pixel_y;
    valid_nx     = pixel_valid;
    done_nx      = 1'b0;
    count_nx     = frame_count;

    case (state)
      IDLE: begin
        x_nx     = '0;
        y_nx     = '0;
        valid_nx = 1'b0;
        if (start && !abort) begin
          state_nx = SCAN;
          valid_nx = 1'b1;
        end
      end

      SCAN: begin
        if (abort) begin
          state_nx = IDLE;
          x_nx     = '0;
          y_nx     = '0;
          valid_nx = 1'b0;
        end else if (!stall) begin
          if (pixel_x == X_LAST) begin
            x_nx = '0;
            if (pixel_y == Y_LAST) begin
              state_nx     = DRAIN;
              y_nx         = '0;
              valid_nx     = 1'b0;
              drain_cnt_nx = CNT_INIT;
            end else begin
              y_nx = pixel_y + 1'b1;
            end
          end else begin
            x_nx = pixel_x + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (abort) begin
          state_nx = IDLE;
          x_nx     = '0;
          y_nx     = '0;
          valid_nx = 1'b0;
        end else if (!stall) begin
          // counter starts at PIPE_LAT-1, so the terminal step is the PIPE_LAT-th
          if (drain_cnt == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            count_nx = frame_count + 1'b1;
          end else begin
            drain_cnt_nx = drain_cnt - 1'b1;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        x_nx     = '0;
        y_nx     = '0;
        valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Testbench for pixel_scheduler: a small 4x3 frame (PIPE_LAT=2) checked by a
// directed vector table, hand sequences and a randomized run against an
// index-based reference model; a wide 800x4 frame (PIPE_LAT=4) for line wrap
// and drain length at the full line width.
module tb_pixel_scheduler;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int SL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, stall;
  logic [9:0] pixel_x, pixel_y;
  logic       pixel_valid, busy, frame_done;
  logic [15:0] frame_count;

  logic       w_start, w_abort, w_stall;
  logic [9:0] w_x, w_y;
  logic       w_valid, w_busy, w_done;
  logic [15:0] w_count;

  pixel_scheduler #(.PIXEL_W(SW), .PIXEL_H(SH), .COORD_W(10), .PIPE_LAT(SL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count));

  pixel_scheduler #(.PIXEL_W(800), .PIXEL_H(4), .COORD_W(10), .PIPE_LAT(4)) dut_wide (
    .clk(clk), .rst(rst), .start(w_start), .abort(w_abort), .stall(w_stall),
    .pixel_x(w_x), .pixel_y(w_y), .pixel_valid(w_valid),
    .busy(w_busy), .frame_done(w_done), .frame_count(w_count));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame progress as a linear pixel index plus a count of
  // drain cycles still owed.  mode 0 idle, 1 scanning, 2 draining.
  int m_mode = 0, m_idx = 0, m_left = 0, m_done = 0, m_count = 0;

  task automatic model_step(input logic r, s, a, st);
    m_done = 0;
    if (r) begin
      m_mode = 0; m_idx = 0; m_count = 0;
    end else if (m_mode == 0) begin
      if (s && !a) begin m_mode = 1; m_idx = 0; end
    end else if (a) begin
      m_mode = 0;
    end else if (!st) begin
      if (m_mode == 1) begin
        if (m_idx == SW*SH - 1) begin m_mode = 2; m_left = SL; end
        else m_idx++;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_done = 1; m_count = (m_count + 1) % 65536;
        end
      end
    end
  endtask

  task automatic tick(input logic r, s, a, st);
    rst = r; start = s; abort = a; stall = st;
    @(posedge clk);
    model_step(r, s, a, st);
    #1;
    chk("m_valid", int'(pixel_valid), (m_mode == 1) ? 1 : 0);
    chk("m_x", int'(pixel_x), (m_mode == 1) ? m_idx % SW : 0);
    chk("m_y", int'(pixel_y), (m_mode == 1) ? m_idx / SW : 0);
    chk("m_busy", int'(busy), (m_mode != 0) ? 1 : 0);
    chk("m_done", int'(frame_done), m_done);
    chk("m_count", int'(frame_count), m_count);
  endtask

  task automatic wtick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, start, abort, stall;
    int   e_valid, e_x, e_y, e_busy, e_done;
  } vec_t;

  vec_t vec[12];
  int   n;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    w_start = 1'b0; w_abort = 1'b0; w_stall = 1'b0;

    //            rst start abort stall | valid x  y busy done
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,   0, 0, 0, 0, 0};
    vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,   0, 0, 0, 0, 0};
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,   0, 0, 0, 0, 0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b1,   0, 0, 0, 0, 0};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b1,   1, 0, 0, 1, 0};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 1, 0, 1, 0};
    vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b1,   1, 1, 0, 1, 0};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 2, 0, 1, 0};
    vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b1,   0, 0, 0, 0, 0};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 0, 0};
    vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 0, 0, 1, 0};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 1, 0, 1, 0};

    for (int i = 0; i < 12; i++) begin
      tick(vec[i].rst, vec[i].start, vec[i].abort, vec[i].stall);
      chk($sformatf("tbl%0d_valid", i), int'(pixel_valid), vec[i].e_valid);
      chk($sformatf("tbl%0d_x", i), int'(pixel_x), vec[i].e_x);
      chk($sformatf("tbl%0d_y", i), int'(pixel_y), vec[i].e_y);
      chk($sformatf("tbl%0d_busy", i), int'(busy), vec[i].e_busy);
      chk($sformatf("tbl%0d_done", i), int'(frame_done), vec[i].e_done);
    end

    // reset then idle
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0);
      chk("idle_valid", int'(pixel_valid), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_count", int'(frame_count), 0);
    end

    // full small frame, no stall
    tick(0, 1, 0, 0);
    for (int i = 0; i < SW*SH; i++) begin
      chk("seq_valid", int'(pixel_valid), 1);
      chk("seq_x", int'(pixel_x), i % SW);
      chk("seq_y", int'(pixel_y), i / SW);
      tick(0, 0, 0, 0);
    end
    for (int i = 0; i < SL; i++) begin
      chk("drain_valid", int'(pixel_valid), 0);
      chk("drain_busy", int'(busy), 1);
      chk("drain_done", int'(frame_done), 0);
      if (i < SL - 1) tick(0, 0, 0, 0);
    end
    tick(0, 0, 0, 0);
    chk("fd_pulse", int'(frame_done), 1);
    chk("fd_busy", int'(busy), 0);
    chk("fd_count", int'(frame_count), 1);

    // back-to-back start in the frame_done cycle, then time the frame
    tick(0, 1, 0, 0);
    chk("b2b_valid", int'(pixel_valid), 1);
    chk("b2b_x", int'(pixel_x), 0);
    chk("b2b_y", int'(pixel_y), 0);
    n = 1;
    while (!frame_done && n < 100) begin tick(0, 0, 0, 0); n++; end
    chk("nostall_len", n, 1 + SW*SH + SL);
    chk("b2b_count", int'(frame_count), 2);

    // stall hold at (2,0)
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("stall_pre_x", int'(pixel_x), 2);
    n = 3;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1); n++;
      chk("stall_hold_x", int'(pixel_x), 2);
      chk("stall_hold_v", int'(pixel_valid), 1);
    end
    tick(0, 0, 0, 0); n++;
    chk("stall_next_x", int'(pixel_x), 3);
    while (!frame_done && n < 100) begin tick(0, 0, 0, 0); n++; end
    chk("stall_len", n, 1 + SW*SH + SL + 5);

    // abort at (1,1): frame_count kept, no frame_done
    tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("abort_pre_x", int'(pixel_x), 1);
    chk("abort_pre_y", int'(pixel_y), 1);
    tick(0, 1, 1, 1);
    chk("abort_valid", int'(pixel_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(frame_count), 1);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0);
      chk("abort_nodone", int'(frame_done), 0);
    end
    tick(0, 1, 0, 0);
    chk("restart_valid", int'(pixel_valid), 1);
    chk("restart_x", int'(pixel_x), 0);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 255) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0));
    end

    // wide frame: line wrap at 799 and 4-cycle drain
    tick(1, 0, 0, 0);
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    w_start = 1'b1;
    wtick();
    w_start = 1'b0;
    chk("w_first_v", int'(w_valid), 1);
    chk("w_first_x", int'(w_x), 0);
    repeat (799) wtick();
    chk("w_eol_x", int'(w_x), 799);
    chk("w_eol_y", int'(w_y), 0);
    wtick();
    chk("w_wrap_x", int'(w_x), 0);
    chk("w_wrap_y", int'(w_y), 1);
    repeat (2399) wtick();
    chk("w_last_x", int'(w_x), 799);
    chk("w_last_y", int'(w_y), 3);
    chk("w_last_v", int'(w_valid), 1);
    wtick();
    chk("w_drain_v", int'(w_valid), 0);
    chk("w_drain_b", int'(w_busy), 1);
    for (int i = 0; i < 3; i++) begin
      wtick();
      chk("w_drain_busy", int'(w_busy), 1);
      chk("w_drain_nodone", int'(w_done), 0);
    end
    wtick();
    chk("w_done", int'(w_done), 1);
    chk("w_done_busy", int'(w_busy), 0);
    chk("w_count", int'(w_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_scheduler.md
# pixel_scheduler

Frame sequencer in front of `generate_ray`. On a start pulse it sweeps every pixel coordinate of a `PIXEL_W` x `PIXEL_H` frame in raster order (x fastest), presenting one coordinate per accepted cycle. It honours the pipeline `stall` line, drains the ray pipeline after the last pixel, then reports frame completion. It is the only driver of `generate_ray`'s `pixel_x`/`pixel_y` inputs.

## Interface
- `PIXEL_W`, 800, pixels per line
- `PIXEL_H`, 600, lines per frame
- `COORD_W`, 10, coordinate width; must satisfy 2^COORD_W >= max(PIXEL_W, PIXEL_H)
- `PIPE_LAT`, 4, accepted cycles needed to flush the downstream ray pipeline after the last pixel (>= 1)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a frame; sampled only in IDLE
- `abort`  in  1  synchronous cancel of the current frame
- `stall`  in  1  downstream stall; when high, no coordinate is accepted and all state holds
- `pixel_x`  out  COORD_W  current column
- `pixel_y`  out  COORD_W  current row
- `pixel_valid`  out  1  `pixel_x`/`pixel_y` carry a real pixel
- `busy`  out  1  high in SCAN and DRAIN
- `frame_done`  out  1  one-cycle pulse when a frame has fully drained
- `frame_count`  out  16  completed frames, wraps 0xFFFF -> 0

## Operation
- States: IDLE, SCAN, DRAIN.
- Reset: state IDLE; `pixel_x`=0, `pixel_y`=0, `pixel_valid`=0, `busy`=0, `frame_done`=0, `frame_count`=0. Reset overrides all other inputs.
- IDLE: outputs `pixel_valid`=0 and coordinates 0. `start`=1 moves to SCAN with `pixel_x`=0, `pixel_y`=0, `pixel_valid`=1. `stall` is ignored in IDLE.
- SCAN, `stall`=0 (pixel accepted):
  - If `pixel_x` < PIXEL_W-1, increment `pixel_x`.
  - Otherwise set `pixel_x`=0 and increment `pixel_y`.
  - At (PIXEL_W-1, PIXEL_H-1), go to DRAIN. Set `pixel_valid`=0, coordinates to 0, and the drain counter to PIPE_LAT-1.
- SCAN, `stall`=1: coordinates, `pixel_valid` and state hold.
- DRAIN: the counter decrements on each `stall`=0 cycle and holds on `stall`=1. When the counter is 0 with `stall`=0: pulse `frame_done`, increment `frame_count`, and go to IDLE.
- `start` outside IDLE is ignored; it does not queue.
- `abort`=1 in SCAN or DRAIN goes to IDLE next cycle, outputs as in reset except `frame_count` is kept; no `frame_done`. `abort` beats `start`, `stall` and the final drain step in the same cycle. `abort` in IDLE has no effect, and wins over a simultaneous `start`.
- Coordinates never exceed PIXEL_W-1 / PIXEL_H-1. There is no overflow path.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Start latency: `start` high at edge N gives `pixel_valid`=1 with (0,0) after edge N.
- Throughput: one pixel per cycle when `stall`=0.
- A frame with no stalls: `start`, then PIXEL_W*PIXEL_H SCAN cycles, then PIPE_LAT DRAIN cycles. `frame_done` is high for the cycle after the last DRAIN edge. The earliest new `start` is accepted on the cycle `frame_done` is high, since the state is already IDLE.
- Each stall cycle in SCAN or DRAIN adds exactly one cycle to the frame.
- `busy` is high exactly while the state is SCAN or DRAIN.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release with `start`=0 -> all outputs 0 for 10 cycles.
- Short frame, no stall (PIXEL_W=4, PIXEL_H=3, PIPE_LAT=2): pulse `start`.
  - Required sequence: (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), 12 valid cycles.
  - Then 2 cycles with `pixel_valid`=0 and `busy`=1, then one `frame_done` pulse; `frame_count`=1.
- Stall hold: after (2,0) is presented, hold `stall`=1 for 5 cycles -> (2,0) held for 6 cycles total, then (3,0). `frame_done` arrives 5 cycles later than in the no-stall case.
- Line and frame wrap at default size: run to (799,0) -> next is (0,1). Reaching (799,599) with `stall`=0 -> `pixel_valid`=0 next cycle, DRAIN entered. With PIPE_LAT=4 and no stall, `frame_done` comes 4 cycles later.
- Abort mid-frame: `abort` at (1,1) in the small config -> next cycle IDLE, `pixel_valid`=0, `busy`=0, no `frame_done`, `frame_count` unchanged. A following `start` restarts at (0,0).
- Start ignored while busy, and back-to-back frames: pulse `start` during SCAN -> no effect on the sequence. Assert `start` in the `frame_done` cycle -> (0,0) valid next cycle. `frame_count` increments by 1 per completed frame.
